sma_arbiter: RTL and testbench



---
 rtl/sma_arbiter.sv | 134 +++++++++++++
 tb/tb_sma_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sma_arbiter.sv
// Two-requester round-robin front end for a single shared SMA bounds-check engine.
// One request in flight at a time: IDLE accepts, EVAL samples the engine, RESP holds the result.
module sma_arbiter #(
  parameter int WORD_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_access_type,
  input  logic [WORD_WIDTH-1:0] req0_pointer,
  input  logic [WORD_WIDTH-1:0] req0_increment,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [WORD_WIDTH-1:0] resp0_address,
  output logic                  resp0_overflow,
  output logic                  resp0_underflow,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_access_type,
  input  logic [WORD_WIDTH-1:0] req1_pointer,
  input  logic [WORD_WIDTH-1:0] req1_increment,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [WORD_WIDTH-1:0] resp1_address,
  output logic                  resp1_overflow,
  output logic                  resp1_underflow,

  output logic [2:0]            eng_access_type,
  output logic [WORD_WIDTH-1:0] eng_tagged_pointer,
  output logic [WORD_WIDTH-1:0] eng_increment,
  input  logic [WORD_WIDTH-1:0] eng_address,
  input  logic                  eng_overflow,
  input  logic                  eng_underflow,

  output logic [CNT_WIDTH-1:0]  fault_count
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t state, next_state;

  logic                  last_grant;
  logic                  grant_id;
  logic                  sel;
  logic                  accept;
  logic                  resp_fire;
  logic [2:0]            op_access_type;
  logic [WORD_WIDTH-1:0] op_pointer;
  logic [WORD_WIDTH-1:0] op_increment;
  logic [WORD_WIDTH-1:0] res_address;
  logic                  res_overflow;
  logic                  res_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // sel picks the requester that did not win last time when both are asking.
  always_comb begin
    next_state  = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    accept      = 1'b0;
    resp_fire   = 1'b0;
    sel         = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !sel;
        req1_ready = req1_valid && sel;
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          next_state = EVAL;
        end
      end
      EVAL: next_state = RESP;
      RESP: begin
        resp0_valid = !grant_id;
        resp1_valid = grant_id;
        resp_fire   = grant_id ? resp1_ready : resp0_ready;
        if (resp_fire) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      op_access_type <= '0;
      op_pointer     <= '0;
      op_increment   <= '0;
      res_address    <= '0;
      res_overflow   <= 1'b0;
      res_underflow  <= 1'b0;
      fault_count    <= '0;
    end else begin
      if (accept) begin
        grant_id       <= sel;
        last_grant     <= sel;
        op_access_type <= sel ? req1_access_type : req0_access_type;
        op_pointer     <= sel ? req1_pointer     : req0_pointer;
        op_increment   <= sel ? req1_increment   : req0_increment;
      end
      if (state == EVAL) begin
        res_address   <= eng_address;
        res_overflow  <= eng_overflow;
        res_underflow <= eng_underflow;
        if ((eng_overflow || eng_underflow) && (fault_count != {CNT_WIDTH{1'b1}}))
          fault_count <= fault_count + CNT_WIDTH'(1);
      end
    end
  end

  // Engine operands come only from registers so the engine never sees raw request inputs.
  assign eng_access_type    = op_access_type;
  assign eng_tagged_pointer = op_pointer;
  assign eng_increment      = op_increment;

  assign resp0_address   = resp0_valid ? res_address : '0;
  assign resp0_overflow  = resp0_valid && res_overflow;
  assign resp0_underflow = resp0_valid && res_underflow;
  assign resp1_address   = resp1_valid ? res_address : '0;
  assign resp1_overflow  = resp1_valid && res_overflow;
  assign resp1_underflow = resp1_valid && res_underflow;

endmodule

// File: tb/tb_sma_arbiter.sv
// Directed bench for sma_arbiter; a small behavioural SMA engine model answers the eng_* port.
// A second instance with a 2-bit fault counter exercises saturation.
module tb_sma_arbiter;
  localparam int W = 64;
  // Tag: length in bytes in [63:58], b_size in [57:52], address in [47:0].
  localparam logic [W-1:0] PTR  = 64'h1000_0000_0000_0100;
  localparam logic [W-1:0] PTR1 = 64'h1000_0000_0000_0110;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_overflow, resp0_underflow;
  logic [2:0]   req0_access_type;
  logic [W-1:0] req0_pointer, req0_increment, resp0_address;
  logic         req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_overflow, resp1_underflow;
  logic [2:0]   req1_access_type;
  logic [W-1:0] req1_pointer, req1_increment, resp1_address;
  logic [2:0]   eng_access_type;
  logic [W-1:0] eng_tagged_pointer, eng_increment, eng_address;
  logic         eng_overflow, eng_underflow;
  logic [15:0]  fault_count;

  logic         s_req0_valid, s_req0_ready, s_resp0_valid, s_resp0_ready, s_resp0_overflow, s_resp0_underflow;
  logic [W-1:0] s_resp0_address;
  logic         s_req1_ready, s_resp1_valid, s_resp1_overflow, s_resp1_underflow;
  logic [W-1:0] s_resp1_address;
  logic [2:0]   s_eng_access_type;
  logic [W-1:0] s_eng_tagged_pointer, s_eng_increment, s_eng_address;
  logic         s_eng_overflow, s_eng_underflow;
  logic [1:0]   s_fault_count;

  int tests = 0;
  int fails = 0;

  // Returns {overflow, underflow, address}; clamps into [base, base+length-size].
  function automatic logic [W+1:0] engine(input logic [2:0] at, input logic [W-1:0] tp,
                                          input logic [W-1:0] inc);
    logic [W-1:0] base, length, size, sum, limit;
    base   = {16'd0, tp[47:0]};
    length = {58'd0, tp[63:58]};
    size   = 64'd1 << at;
    sum    = base + inc;
    limit  = base + length;
    if ($signed(inc) < 0)       return {1'b0, 1'b1, base};
    if (sum + size > limit)     return {1'b1, 1'b0, limit - size};
    return {1'b0, 1'b0, sum};
  endfunction

  assign {eng_overflow, eng_underflow, eng_address} =
    engine(eng_access_type, eng_tagged_pointer, eng_increment);
  assign {s_eng_overflow, s_eng_underflow, s_eng_address} =
    engine(s_eng_access_type, s_eng_tagged_pointer, s_eng_increment);

  sma_arbiter #(.WORD_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_access_type(req0_access_type),
    .req0_pointer(req0_pointer), .req0_increment(req0_increment),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_address(resp0_address),
    .resp0_overflow(resp0_overflow), .resp0_underflow(resp0_underflow),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_access_type(req1_access_type),
    .req1_pointer(req1_pointer), .req1_increment(req1_increment),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_address(resp1_address),
    .resp1_overflow(resp1_overflow), .resp1_underflow(resp1_underflow),
    .eng_access_type(eng_access_type), .eng_tagged_pointer(eng_tagged_pointer),
    .eng_increment(eng_increment), .eng_address(eng_address),
    .eng_overflow(eng_overflow), .eng_underflow(eng_underflow),
    .fault_count(fault_count)
  );

  sma_arbiter #(.WORD_WIDTH(W), .CNT_WIDTH(2)) sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_access_type(3'd0),
    .req0_pointer(PTR), .req0_increment(64'd8),
    .resp0_valid(s_resp0_valid), .resp0_ready(s_resp0_ready), .resp0_address(s_resp0_address),
    .resp0_overflow(s_resp0_overflow), .resp0_underflow(s_resp0_underflow),
    .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_access_type(3'd0),
    .req1_pointer(64'd0), .req1_increment(64'd0),
    .resp1_valid(s_resp1_valid), .resp1_ready(1'b1), .resp1_address(s_resp1_address),
    .resp1_overflow(s_resp1_overflow), .resp1_underflow(s_resp1_underflow),
    .eng_access_type(s_eng_access_type), .eng_tagged_pointer(s_eng_tagged_pointer),
    .eng_increment(s_eng_increment), .eng_address(s_eng_address),
    .eng_overflow(s_eng_overflow), .eng_underflow(s_eng_underflow),
    .fault_count(s_fault_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_handshake: got %b expected 0000",
                        {req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
    tests++;
    if ({eng_access_type, eng_tagged_pointer, eng_increment} !== '0) begin
      fails++; $display("[TB] FAIL reset_eng: got %h/%h/%h expected 0",
                        eng_access_type, eng_tagged_pointer, eng_increment);
    end
    tests++;
    if (fault_count !== 16'd0 || resp0_address !== '0) begin
      fails++; $display("[TB] FAIL reset_count: got %0d/%h expected 0/0", fault_count, resp0_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    req0_valid = 1'b1; req0_access_type = 3'd0; req0_pointer = PTR; req0_increment = 64'd2;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick;
    req0_valid = 1'b0;
    tests++;
    if (resp0_valid !== 1'b0 || req0_ready !== 1'b0 || eng_tagged_pointer !== PTR || eng_increment !== 64'd2) begin
      fails++; $display("[TB] FAIL single_eval: got valid %b ready %b ptr %h inc %h expected 0 0 %h 2",
                        resp0_valid, req0_ready, eng_tagged_pointer, eng_increment, PTR);
    end
    tick;
    tests++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_address !== 64'h102 ||
        resp0_overflow !== 1'b0 || resp0_underflow !== 1'b0 || fault_count !== 16'd0) begin
      fails++; $display("[TB] FAIL single_resp: got v%b%b addr %h o%b u%b cnt %0d expected v10 addr 102 o0 u0 cnt 0",
                        resp0_valid, resp1_valid, resp0_address, resp0_overflow, resp0_underflow, fault_count);
    end
    tick;
    tests++;
    if (resp0_valid !== 1'b0 || resp0_address !== '0) begin
      fails++; $display("[TB] FAIL single_done: got v%b addr %h expected v0 addr 0", resp0_valid, resp0_address);
    end
  endtask

  task automatic test_overflow;
    req1_valid = 1'b1; req1_access_type = 3'd0; req1_pointer = PTR; req1_increment = 64'd8;
    #1;
    tests++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL ovf_ready: got %b%b expected 01", req0_ready, req1_ready);
    end
    tick;
    req1_valid = 1'b0;
    tick;
    tests++;
    if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_address !== 64'h103 ||
        resp1_overflow !== 1'b1 || resp1_underflow !== 1'b0 || fault_count !== 16'd1) begin
      fails++; $display("[TB] FAIL ovf_resp: got v%b%b addr %h o%b u%b cnt %0d expected v01 addr 103 o1 u0 cnt 1",
                        resp0_valid, resp1_valid, resp1_address, resp1_overflow, resp1_underflow, fault_count);
    end
    tick;
    tests++;
    if (resp1_valid !== 1'b0 || resp1_overflow !== 1'b0) begin
      fails++; $display("[TB] FAIL ovf_done: got v%b o%b expected v0 o0", resp1_valid, resp1_overflow);
    end
  endtask

  task automatic test_contention;
    logic [W-1:0] exp_addr;
    test_reset;
    req0_pointer = PTR;  req0_increment = 64'd1; req0_access_type = 3'd0;
    req1_pointer = PTR1; req1_increment = 64'd1; req1_access_type = 3'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 64'h101 : 64'h111;
      tests++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++; $display("[TB] FAIL contention_grant%0d: got %b%b expected %0d", i, req0_ready, req1_ready, i % 2);
      end
      tick;
      tests++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
        fails++; $display("[TB] FAIL contention_eval%0d: got %b expected 0000", i,
                          {req0_ready, req1_ready, resp0_valid, resp1_valid});
      end
      tick;
      tests++;
      if ({resp0_valid, resp1_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          (resp0_address | resp1_address) !== exp_addr) begin
        fails++; $display("[TB] FAIL contention_resp%0d: got v%b%b addr %h expected grant %0d addr %h", i,
                          resp0_valid, resp1_valid, resp0_address | resp1_address, i % 2, exp_addr);
      end
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++;
    if (fault_count !== 16'd0) begin
      fails++; $display("[TB] FAIL contention_count: got %0d expected 0", fault_count);
    end
  endtask

  task automatic test_backpressure;
    resp0_ready = 1'b0;
    req0_pointer = PTR; req0_increment = 64'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("[TB] FAIL bp_grant: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick;
    req0_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (resp0_valid !== 1'b1 || resp0_address !== 64'h102 || resp0_overflow !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++; $display("[TB] FAIL bp_hold%0d: got v%b addr %h o%b rdy %b%b expected v1 addr 102 o0 rdy 00",
                          i, resp0_valid, resp0_address, resp0_overflow, req0_ready, req1_ready);
      end
      tick;
    end
    resp0_ready = 1'b1;
    #1;
    tests++;
    if (resp0_valid !== 1'b1 || resp0_address !== 64'h102) begin
      fails++; $display("[TB] FAIL bp_last: got v%b addr %h expected v1 addr 102", resp0_valid, resp0_address);
    end
    tick;
    tests++;
    if (resp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_idle: got v%b rdy1 %b expected v0 rdy1 1", resp0_valid, req1_ready);
    end
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_eval;
    req0_pointer = PTR; req0_increment = 64'd8; req0_valid = 1'b1;
    #1;
    tick;
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000 ||
        eng_tagged_pointer !== '0 || eng_increment !== '0 || fault_count !== 16'd0) begin
      fails++; $display("[TB] FAIL midrst_zero: got hs %b ptr %h inc %h cnt %0d expected all 0",
                        {req0_ready, req1_ready, resp0_valid, resp1_valid}, eng_tagged_pointer, eng_increment, fault_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || fault_count !== 16'd0) begin
        fails++; $display("[TB] FAIL midrst_quiet%0d: got v%b%b cnt %0d expected v00 cnt 0",
                          i, resp0_valid, resp1_valid, fault_count);
      end
    end
    req1_pointer = PTR; req1_increment = 64'd2; req1_valid = 1'b1;
    #1;
    tests++;
    if (req1_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL midrst_accept: got %b expected 1", req1_ready);
    end
    tick;
    req1_valid = 1'b0;
    tick;
    tests++;
    if (resp1_valid !== 1'b1 || resp1_address !== 64'h102 || resp1_overflow !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_resp: got v%b addr %h o%b expected v1 addr 102 o0",
                        resp1_valid, resp1_address, resp1_overflow);
    end
    tick;
  endtask

  task automatic test_saturation;
    s_resp0_ready = 1'b1;
    s_req0_valid  = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick;
      tick;
      tests++;
      if (s_resp0_valid !== 1'b1 || s_resp0_overflow !== 1'b1 ||
          s_fault_count !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
        fails++; $display("[TB] FAIL sat_count%0d: got v%b o%b cnt %0d expected v1 o1 cnt %0d",
                          i, s_resp0_valid, s_resp0_overflow, s_fault_count, (i < 3) ? i + 1 : 3);
      end
      tick;
    end
    s_req0_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req0_access_type = '0; req0_pointer = '0; req0_increment = '0;
    req1_valid = 1'b0; req1_access_type = '0; req1_pointer = '0; req1_increment = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    s_req0_valid = 1'b0; s_resp0_ready = 1'b1;
    #2;
    test_reset;
    test_single;
    test_overflow;
    test_contention;
    test_backpressure;
    test_reset_mid_eval;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
